// File: rtl/bmem_arbiter_if.sv
// Bus bundle between the I/D caches, burst memory, cacheline_adapter and bmem_arbiter.
// The arbiter takes the slave view; the surrounding logic (or a bench) takes the master view.
interface bmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_read;
    logic [LINE_W-1:0] imem_rdata;
    logic              imem_resp;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_read;
    logic              dmem_write;
    logic [LINE_W-1:0] dmem_wdata;
    logic [LINE_W-1:0] dmem_rdata;
    logic              dmem_resp;
    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_ready;
    logic              mem_valid;
    logic [LINE_W-1:0] full_burst;
    logic              cache_valid;
    logic [LINE_W-1:0] cache_wdata;
    logic              d_cache_valid;

    modport slave (
        input  imem_addr, imem_read, dmem_addr, dmem_read, dmem_write, dmem_wdata,
               bmem_ready, cache_valid, cache_wdata, d_cache_valid,
        output imem_rdata, imem_resp, dmem_rdata, dmem_resp, bmem_addr, bmem_read,
               mem_valid, full_burst
    );

    modport master (
        output imem_addr, imem_read, dmem_addr, dmem_read, dmem_write, dmem_wdata,
               bmem_ready, cache_valid, cache_wdata, d_cache_valid,
        input  imem_rdata, imem_resp, dmem_rdata, dmem_resp, bmem_addr, bmem_read,
               mem_valid, full_burst
    );
endinterface

// File: rtl/bmem_arbiter.sv
// Single-outstanding arbiter of I/D cache-line fills and D writebacks onto the burst port.
// Define ARB_RR_EN for round-robin I/D tie-breaking; otherwise D always beats I.
module bmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic           clk,
    input  logic           rst,
    bmem_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CMD,
        S_RD_WAIT,
        S_WR_CMD,
        S_WR_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_owner_d;
    logic [LINE_W-1:0] r_irdata;
    logic [LINE_W-1:0] r_drdata;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_pick_d;
    logic              w_grant;
    logic              w_grant_d;
    logic              w_grant_wr;
    logic              w_bmem_read;
    logic              w_mem_valid;
    logic [ADDR_W-1:0] w_addr_out;
    logic [LINE_W-1:0] w_burst_out;
    logic              w_iresp;
    logic              w_dresp;
    logic [ADDR_W-1:0] w_iaddr_al;
    logic [ADDR_W-1:0] w_daddr_al;

    assign w_i_req    = bus.imem_read;
    assign w_d_req    = bus.dmem_read | bus.dmem_write;
    assign w_iaddr_al = {bus.imem_addr[ADDR_W-1:5], 5'b0};
    assign w_daddr_al = {bus.dmem_addr[ADDR_W-1:5], 5'b0};

`ifdef ARB_RR_EN
    // Set means D wins the next tie; flips to the port that was not just granted.
    logic r_prio_d;
    assign w_pick_d = w_d_req & (~w_i_req | r_prio_d);
`else
    assign w_pick_d = w_d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_owner_d <= 1'b0;
            r_irdata  <= '0;
            r_drdata  <= '0;
`ifdef ARB_RR_EN
            r_prio_d  <= 1'b1;
`endif
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_owner_d <= w_grant_d;
                r_addr    <= w_grant_d ? w_daddr_al : w_iaddr_al;
                if (w_grant_wr)
                    r_wdata <= bus.dmem_wdata;
`ifdef ARB_RR_EN
                r_prio_d <= ~w_grant_d;
`endif
            end
            if (r_state == S_RD_WAIT && bus.cache_valid) begin
                if (r_owner_d)
                    r_drdata <= bus.cache_wdata;
                else
                    r_irdata <= bus.cache_wdata;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_grant     = 1'b0;
        w_grant_d   = 1'b0;
        w_grant_wr  = 1'b0;
        w_bmem_read = 1'b0;
        w_mem_valid = 1'b0;
        w_addr_out  = '0;
        w_burst_out = '0;
        w_iresp     = 1'b0;
        w_dresp     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_d_req || w_i_req) begin
                    w_grant    = 1'b1;
                    w_grant_d  = w_pick_d;
                    // A D-cache holding both read and write gets its writeback first.
                    w_grant_wr = w_pick_d & bus.dmem_write;
                    w_next     = w_grant_wr ? S_WR_CMD : S_RD_CMD;
                end
            end
            S_RD_CMD: begin
                w_addr_out = r_addr;
                if (bus.bmem_ready) begin
                    w_bmem_read = 1'b1;
                    w_next      = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                w_addr_out = r_addr;
                if (bus.cache_valid)
                    w_next = S_RESP;
            end
            S_WR_CMD: begin
                w_addr_out  = r_addr;
                w_burst_out = r_wdata;
                if (bus.bmem_ready) begin
                    w_mem_valid = 1'b1;
                    w_next      = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                w_addr_out  = r_addr;
                w_burst_out = r_wdata;
                if (bus.d_cache_valid)
                    w_next = S_RESP;
            end
            S_RESP: begin
                w_iresp = ~r_owner_d;
                w_dresp = r_owner_d;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.bmem_addr  = w_addr_out;
    assign bus.bmem_read  = w_bmem_read;
    assign bus.mem_valid  = w_mem_valid;
    assign bus.full_burst = w_burst_out;
    assign bus.imem_resp  = w_iresp;
    assign bus.dmem_resp  = w_dresp;
    assign bus.imem_rdata = r_irdata;
    assign bus.dmem_rdata = r_drdata;
endmodule
